// File: rtl/cpu_control_unit.sv
// Multi-cycle instruction controller for the 16-bit core.
// Latches IR, splits fields, sequences datapath strobes.
module cpu_control_unit (
  input  logic        clk,
  input  logic        Rst,
  input  logic [15:0] inst,
  input  logic [4:0]  flags_in,
  output logic [5:0]  opcode,
  output logic [4:0]  reg_addr1,
  output logic [4:0]  reg_addr2,
  output logic [4:0]  imd_operand,
  output logic [4:0]  mem_addr,
  output logic [15:0] imd_addr,
  output logic        mem_wr,
  output logic        reg_wr,
  output logic        IorR,
  output logic        PcorR,
  output logic        Pc_Rst,
  output logic        Pc_Ld,
  output logic        pc_addr_sel,
  output logic        st_reg_ld,
  output logic [1:0]  Din_Sel
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] C_ALU_RR = 3'b000;
  localparam logic [2:0] C_ALU_RI = 3'b001;
  localparam logic [2:0] C_LOAD   = 3'b010;
  localparam logic [2:0] C_STORE  = 3'b011;
  localparam logic [2:0] C_JUMP   = 3'b100;
  localparam logic [2:0] C_BRANCH = 3'b101;
  localparam logic [2:0] C_HALT   = 3'b110;

  localparam logic [1:0] DIN_ALU = 2'b00;
  localparam logic [1:0] DIN_MEM = 2'b01;
  localparam logic [1:0] DIN_IMM = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic [15:0] ir_vis;
  logic [2:0]  cls;
  logic [2:0]  sub;

  logic is_rr;
  logic is_ri;
  logic is_ldi;
  logic is_ld;
  logic is_st;
  logic is_jmp;
  logic is_br;
  logic is_hlt;
  logic has_wb;
  logic br_taken;

  logic f_z;
  logic f_c;
  logic f_s;
  logic f_v;
  logic f_p;

  assign cls = ir[15:13];
  assign sub = ir[12:10];

  assign is_rr  = (cls == C_ALU_RR);
  assign is_ri  = (cls == C_ALU_RI);
  assign is_ldi = is_ri && (sub == 3'b111);
  assign is_ld  = (cls == C_LOAD);
  assign is_st  = (cls == C_STORE);
  assign is_jmp = (cls == C_JUMP);
  assign is_br  = (cls == C_BRANCH);
  assign is_hlt = (cls == C_HALT);
  assign has_wb = is_rr | is_ri | is_ld;

  assign f_z = flags_in[0];
  assign f_c = flags_in[1];
  assign f_s = flags_in[2];
  assign f_v = flags_in[3];
  assign f_p = flags_in[4];

  // Branch condition selected by IR[12:10]
  always_comb begin
    br_taken = 1'b0;
    unique case (sub)
      3'b000:  br_taken = f_z;
      3'b001:  br_taken = f_c;
      3'b010:  br_taken = f_s;
      3'b011:  br_taken = f_v;
      3'b100:  br_taken = f_p;
      3'b101:  br_taken = ~f_z;
      3'b110:  br_taken = ~f_c;
      default: br_taken = 1'b1;
    endcase
  end

  // State register; Rst wins from any state
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= S_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Instruction register, captured only as FETCH ends
  always_ff @(posedge clk) begin
    if (Rst) begin
      ir <= '0;
    end else if (state == S_FETCH) begin
      ir <= inst;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_nxt = S_RST;
    unique case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          has_wb:  state_nxt = S_WB;
          is_hlt:  state_nxt = S_HALT;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_RST;
    endcase
  end

  // Field outputs follow IR except while held in reset
  assign ir_vis      = (state == S_RST) ? '0 : ir;
  assign opcode      = ir_vis[15:10];
  assign reg_addr1   = ir_vis[9:5];
  assign reg_addr2   = ir_vis[4:0];
  assign imd_operand = ir_vis[4:0];
  assign mem_addr    = ir_vis[4:0];
  assign imd_addr    = {6'b0, ir_vis[9:0]};

  // Strobe generation per state and instruction class
  always_comb begin
    mem_wr      = 1'b0;
    reg_wr      = 1'b0;
    IorR        = 1'b0;
    PcorR       = 1'b0;
    Pc_Rst      = 1'b0;
    Pc_Ld       = 1'b0;
    pc_addr_sel = 1'b0;
    st_reg_ld   = 1'b0;
    Din_Sel     = DIN_ALU;
    unique case (state)
      S_RST: begin
        Pc_Rst = 1'b1;
      end
      S_FETCH: begin
        Pc_Ld = 1'b1;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_rr: begin
            st_reg_ld = 1'b1;
          end
          is_ri: begin
            IorR      = 1'b1;
            st_reg_ld = ~is_ldi;
          end
          is_st: begin
            mem_wr = 1'b1;
          end
          is_jmp: begin
            Pc_Ld       = 1'b1;
            pc_addr_sel = 1'b1;
          end
          is_br: begin
            Pc_Ld       = br_taken;
            pc_addr_sel = br_taken;
            PcorR       = br_taken;
          end
          default: ;
        endcase
      end
      S_WB: begin
        reg_wr = 1'b1;
        unique case (1'b1)
          is_ld:   Din_Sel = DIN_MEM;
          is_ldi:  Din_Sel = DIN_IMM;
          default: Din_Sel = DIN_ALU;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed steps then random
// instructions checked against a per-class cycle table.
module tb_cpu_control_unit;

  logic        clk;
  logic        Rst;
  logic [15:0] inst;
  logic [4:0]  flags_in;
  logic [5:0]  opcode;
  logic [4:0]  reg_addr1;
  logic [4:0]  reg_addr2;
  logic [4:0]  imd_operand;
  logic [4:0]  mem_addr;
  logic [15:0] imd_addr;
  logic        mem_wr;
  logic        reg_wr;
  logic        IorR;
  logic        PcorR;
  logic        Pc_Rst;
  logic        Pc_Ld;
  logic        pc_addr_sel;
  logic        st_reg_ld;
  logic [1:0]  Din_Sel;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] prev_ir = '0;

  cpu_control_unit dut (
    .clk(clk), .Rst(Rst), .inst(inst), .flags_in(flags_in),
    .opcode(opcode), .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
    .imd_operand(imd_operand), .mem_addr(mem_addr), .imd_addr(imd_addr),
    .mem_wr(mem_wr), .reg_wr(reg_wr), .IorR(IorR), .PcorR(PcorR),
    .Pc_Rst(Pc_Rst), .Pc_Ld(Pc_Ld), .pc_addr_sel(pc_addr_sel),
    .st_reg_ld(st_reg_ld), .Din_Sel(Din_Sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [9:0] obs_st = {mem_wr, reg_wr, IorR, PcorR, Pc_Rst,
                       Pc_Ld, pc_addr_sel, st_reg_ld, Din_Sel};
  wire [41:0] obs_fld = {opcode, reg_addr1, reg_addr2,
                         imd_operand, mem_addr, imd_addr};

  function automatic logic [9:0] mk(
    input bit mw, input bit rw, input bit ir_, input bit pr,
    input bit prst, input bit pld, input bit sel, input bit st,
    input logic [1:0] din);
    return {mw, rw, ir_, pr, prst, pld, sel, st, din};
  endfunction

  function automatic logic [41:0] fields(input logic [15:0] w);
    logic [15:0] ia;
    ia = {6'b0, w[9:0]};
    return {w[15:10], w[9:5], w[4:0], w[4:0], w[4:0], ia};
  endfunction

  function automatic bit taken(input logic [2:0] c, input logic [4:0] f);
    // flags_in = {P,V,S,C,Z}; 0..4 test a flag, 5/6 negate Z/C, 7 always
    if (c == 3'd7) return 1'b1;
    if (c >= 3'd5) return ~f[c - 3'd5];
    return f[c];
  endfunction

  task automatic chk(input string tag, input logic [9:0] es,
                     input logic [41:0] ef);
    n_assert++;
    assert (obs_st === es) else begin
      n_fail++;
      $error("FAIL %s strobes observed=%b expected=%b", tag, obs_st, es);
    end
    n_assert++;
    assert (obs_fld === ef) else begin
      n_fail++;
      $error("FAIL %s fields observed=%h expected=%h", tag, obs_fld, ef);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for n cycles, then release into FETCH
  task automatic do_reset(input int n, input logic [15:0] w);
    Rst  = 1'b1;
    inst = w;
    for (int i = 0; i < n; i++) begin
      step();
      chk("reset", mk(0,0,0,0,1,0,0,0,2'b00), '0);
    end
    Rst = 1'b0;
    step();
    prev_ir = '0;
  endtask

  // Entered with DUT in FETCH; returns with DUT in FETCH again
  task automatic run_inst(input logic [15:0] w, input logic [4:0] fl,
                          input bit abort_wb, input bit scramble);
    logic [2:0] c;
    logic [2:0] s;
    logic [9:0] ex;
    logic [1:0] din;
    bit         wb;
    c  = w[15:13];
    s  = w[12:10];
    wb = (c <= 3'd2);
    inst     = w;
    flags_in = scramble ? 5'($urandom) : ~fl;
    chk("fetch", mk(0,0,0,0,0,1,0,0,2'b00), fields(prev_ir));
    step();
    if (scramble) inst = 16'($urandom);
    chk("decode", '0, fields(w));
    flags_in = fl;
    step();
    if (scramble) inst = 16'($urandom);
    unique case (c)
      3'd0: ex = mk(0,0,0,0,0,0,0,1,2'b00);
      3'd1: ex = mk(0,0,1,0,0,0,0,s != 3'd7,2'b00);
      3'd3: ex = mk(1,0,0,0,0,0,0,0,2'b00);
      3'd4: ex = mk(0,0,0,0,0,1,1,0,2'b00);
      3'd5: ex = taken(s, fl) ? mk(0,0,0,1,0,1,1,0,2'b00) : '0;
      default: ex = '0;
    endcase
    chk("exec", ex, fields(w));
    prev_ir = w;
    if (wb) begin
      step();
      if (scramble) flags_in = 5'($urandom);
      din = (c == 3'd2) ? 2'b01 : ((c == 3'd1 && s == 3'd7) ? 2'b10 : 2'b00);
      chk("wb", mk(0,1,0,0,0,0,0,0,din), fields(w));
      if (abort_wb) begin
        Rst = 1'b1;
        step();
        chk("rst_mid_wb", mk(0,0,0,0,1,0,0,0,2'b00), '0);
        Rst = 1'b0;
        prev_ir = '0;
      end
    end else if (c == 3'd6) begin
      for (int i = 0; i < 4; i++) begin
        step();
        inst     = 16'($urandom);
        flags_in = 5'($urandom);
        chk("halt", '0, fields(w));
      end
      do_reset(2, 16'($urandom));
      return;
    end
    step();
  endtask

  initial begin
    logic [15:0] w;
    Rst      = 1'b1;
    inst     = 16'h0020;
    flags_in = '0;
    do_reset(4, 16'h0020);

    run_inst(16'b001_011_00001_00000, 5'b0, 1'b0, 1'b0);
    n_assert++;
    assert (opcode === 6'b001011 && reg_addr1 === 5'd1) else begin
      n_fail++;
      $error("FAIL ri_fields observed=%b/%0d expected=001011/1",
             opcode, reg_addr1);
    end
    run_inst(16'b001_111_00011_10101, 5'b0, 1'b0, 1'b0);
    run_inst(16'b000_010_00100_00110, 5'b0, 1'b0, 1'b0);
    run_inst(16'b010_000_00001_01000, 5'b0, 1'b0, 1'b0);
    run_inst(16'b011_000_00001_00001, 5'b0, 1'b0, 1'b0);
    run_inst(16'b100_000_0000001010, 5'b0, 1'b0, 1'b0);
    n_assert++;
    assert (imd_addr === 16'h000A) else begin
      n_fail++;
      $error("FAIL jump_addr observed=%h expected=000a", imd_addr);
    end
    run_inst(16'b101_000_00001_00010, 5'b00001, 1'b0, 1'b0);
    run_inst(16'b101_000_00001_00010, 5'b00000, 1'b0, 1'b0);
    for (int cc = 0; cc < 8; cc++) begin
      w = {3'b101, 3'(cc), 10'h3C5};
      run_inst(w, 5'b10101, 1'b0, 1'b0);
      run_inst(w, 5'b01010, 1'b0, 1'b0);
    end
    run_inst(16'b111_000_00000_00000, 5'b0, 1'b0, 1'b0);
    run_inst(16'b110_000_00000_00000, 5'b0, 1'b0, 1'b0);
    run_inst(16'b000_001_00010_00011, 5'b0, 1'b1, 1'b0);

    for (int k = 0; k < 300; k++) begin
      w = 16'($urandom);
      run_inst(w, 5'($urandom), ($urandom_range(0, 15) == 0), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
